// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: decodes op/funct from the IR and sequences
// fetch/decode/execute/memory/writeback, driving ALU control and datapath enables.
module mc_ctrl_fsm #(
    parameter int         CNT_W       = 32,
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             upover,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic             i_or_d,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_zero,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_ctr,
    output logic [3:0]       state,
    output logic             ovf_flag,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXE    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_reg;
    state_t state_next;
    logic   ov_q;
    logic   r_ok;
    logic   retire;
    logic [1:0] r_alu_ctr;

    assign state = state_reg;

    always_comb begin
        r_ok      = 1'b1;
        r_alu_ctr = 2'b00;
        case (funct)
            6'b100001: r_alu_ctr = 2'b00;
            6'b100011: r_alu_ctr = 2'b01;
            6'b100101: r_alu_ctr = 2'b10;
            6'b101010: r_alu_ctr = 2'b11;
            default:   r_ok      = 1'b0;
        endcase
    end

    // Every state that ends an instruction returns to FETCH and retires it.
    assign retire = (state_reg == S_MEMWB) || (state_reg == S_MEMWR) ||
                    (state_reg == S_ALUWB) || (state_reg == S_BRANCH) ||
                    (state_reg == S_JUMP);

    always_comb begin
        state_next = S_FETCH;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        pc_src     = 2'b00;
        alu_ctr    = 2'b00;
        illegal    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_wr      = 1'b1;
                pc_wr      = 1'b1;
                alu_src_b  = 2'b01;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW:    state_next = S_MEMADR;
                    OP_ADDI, OP_ORI: state_next = S_EXE;
                    OP_BEQ:          state_next = S_BRANCH;
                    OP_J:            state_next = S_JUMP;
                    OP_R: begin
                        if (r_ok) state_next = S_EXE;
                        else      illegal    = 1'b1;
                    end
                    default:         illegal    = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                i_or_d     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                i_or_d = 1'b1;
                mem_wr = 1'b1;
            end
            S_EXE: begin
                alu_src_a  = 1'b1;
                state_next = S_ALUWB;
                if (op == OP_R) begin
                    alu_src_b = 2'b00;
                    alu_ctr   = r_alu_ctr;
                end else if (op == OP_ORI) begin
                    alu_src_b = 2'b10;
                    ext_zero  = 1'b1;
                    alu_ctr   = 2'b10;
                end else begin
                    alu_src_b = 2'b10;
                end
            end
            S_ALUWB: begin
                reg_dst = (op == OP_R);
                reg_wr  = !ov_q;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctr   = 2'b01;
                pc_src    = 2'b01;
                pc_wr     = zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_wr  = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= state_t'(RESET_STATE);
            ov_q      <= 1'b0;
            ovf_flag  <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state_reg <= state_next;
            // Only addi traps on signed overflow; addu/subu ignore it.
            if (state_reg == S_EXE)
                ov_q <= upover & (op == OP_ADDI);
            if ((state_reg == S_ALUWB) && ov_q)
                ovf_flag <= 1'b1;
            if (retire)
                instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed per-cycle sequences, a vector
// table of whole instructions, and random instructions against a behavioural model.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op, funct;
    logic        zero, upover;

    logic        pc_wr, ir_wr, mem_wr, reg_wr, i_or_d, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, pc_src, alu_ctr;
    logic        ext_zero, ovf_flag, illegal;
    logic [3:0]  state;
    logic [31:0] instr_cnt;

    logic        w_pc_wr, w_ir_wr, w_mem_wr, w_reg_wr, w_i_or_d, w_reg_dst, w_mem_to_reg, w_alu_src_a;
    logic [1:0]  w_alu_src_b, w_pc_src, w_alu_ctr;
    logic        w_ext_zero, w_ovf_flag, w_illegal;
    logic [3:0]  w_state;
    logic [3:0]  w_instr_cnt;

    mc_ctrl_fsm #(.CNT_W(32), .RESET_STATE(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .upover(upover),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .mem_wr(mem_wr), .reg_wr(reg_wr), .i_or_d(i_or_d),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_src(pc_src), .alu_ctr(alu_ctr),
        .state(state), .ovf_flag(ovf_flag), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    mc_ctrl_fsm #(.CNT_W(4), .RESET_STATE(4'd0)) dut4 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .upover(upover),
        .pc_wr(w_pc_wr), .ir_wr(w_ir_wr), .mem_wr(w_mem_wr), .reg_wr(w_reg_wr), .i_or_d(w_i_or_d),
        .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .alu_src_a(w_alu_src_a),
        .alu_src_b(w_alu_src_b), .ext_zero(w_ext_zero), .pc_src(w_pc_src), .alu_ctr(w_alu_ctr),
        .state(w_state), .ovf_flag(w_ovf_flag), .illegal(w_illegal), .instr_cnt(w_instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       upover;
        logic [7:0] lat;
        logic [7:0] regwr;
        logic [7:0] memwr;
        logic [7:0] pcwr;
        logic [7:0] ill;
        logic [7:0] dcnt;
    } vec_t;

    typedef enum {K_LW, K_SW, K_ALU, K_BEQ, K_J, K_ILL} kind_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt;
    logic        exp_ovf;
    vec_t        vecs[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [3:0] s);
        int n = 0;
        while (state !== s && n < 12) begin
            step();
            n++;
        end
        chk($sformatf("reach_state_%0d", s), {28'd0, state}, {28'd0, s});
    endtask

    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b001000, 6'b001101: return K_ALU;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000000: return (f == 6'b100001 || f == 6'b100011 ||
                               f == 6'b100101 || f == 6'b101010) ? K_ALU : K_ILL;
            default:   return K_ILL;
        endcase
    endfunction

    // Instruction-level reference: latency and how many of each write pulse to expect.
    function automatic vec_t model(input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input logic u);
        vec_t  v;
        kind_t k = classify(o, f);
        v = '0;
        v.op = o; v.funct = f; v.zero = z; v.upover = u;
        v.pcwr = 8'd1;
        v.dcnt = 8'd1;
        case (k)
            K_LW:  begin v.lat = 8'd5; v.regwr = 8'd1; end
            K_SW:  begin v.lat = 8'd4; v.memwr = 8'd1; end
            K_ALU: begin v.lat = 8'd4; v.regwr = (o == 6'b001000 && u) ? 8'd0 : 8'd1; end
            K_BEQ: begin v.lat = 8'd3; v.pcwr = z ? 8'd2 : 8'd1; end
            K_J:   begin v.lat = 8'd3; v.pcwr = 8'd2; end
            default: begin v.lat = 8'd2; v.ill = 8'd1; v.dcnt = 8'd0; end
        endcase
        return v;
    endfunction

    function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input logic u, input int lat, input int rw, input int mw,
                                input int pw, input int il, input int dc);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.upover = u;
        v.lat = 8'(lat); v.regwr = 8'(rw); v.memwr = 8'(mw);
        v.pcwr = 8'(pw); v.ill = 8'(il); v.dcnt = 8'(dc);
        return v;
    endfunction

    // Runs one instruction from FETCH back to FETCH and compares pulse counts.
    task automatic do_instr(input string tag, input vec_t e);
        int   n = 0;
        vec_t o = '0;
        op = e.op; funct = e.funct; zero = e.zero; upover = e.upover;
        #1;
        do begin
            o.regwr += 8'(reg_wr);
            o.memwr += 8'(mem_wr);
            o.pcwr  += 8'(pc_wr);
            o.ill   += 8'(illegal);
            o.lat   += 8'd1;
            step();
            n++;
        end while (state != 4'd0 && n < 20);
        if (state != 4'd0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: state %0d expected 0 within 20 cycles", tag, state);
        end
        exp_cnt = exp_cnt + 32'(e.dcnt);
        if (e.op == 6'b001000 && e.upover) exp_ovf = 1'b1;
        chk({tag, "_lat"},   32'(o.lat),   32'(e.lat));
        chk({tag, "_regwr"}, 32'(o.regwr), 32'(e.regwr));
        chk({tag, "_memwr"}, 32'(o.memwr), 32'(e.memwr));
        chk({tag, "_pcwr"},  32'(o.pcwr),  32'(e.pcwr));
        chk({tag, "_ill"},   32'(o.ill),   32'(e.ill));
        chk({tag, "_cnt"},   instr_cnt,    exp_cnt);
        chk({tag, "_cnt4"},  32'(w_instr_cnt), 32'(exp_cnt[3:0]));
        chk({tag, "_ovf"},   32'(ovf_flag),    32'(exp_ovf));
        $display("%s op=%b funct=%b z=%0d u=%0d lat=%0d cnt=%0d ovf=%0d",
                 tag, e.op, e.funct, e.zero, e.upover, o.lat, instr_cnt, ovf_flag);
    endtask

    initial begin
        logic [4:0]  lw_states[5];
        logic [5:0]  op_list[8];
        logic [5:0]  fn_list[4];
        logic [31:0] r;
        logic [5:0]  ro, rf;

        vecs[0]  = mk(6'b100011, 6'b000000, 0, 0, 5, 1, 0, 1, 0, 1);
        vecs[1]  = mk(6'b101011, 6'b000000, 0, 0, 4, 0, 1, 1, 0, 1);
        vecs[2]  = mk(6'b000000, 6'b100001, 0, 1, 4, 1, 0, 1, 0, 1);
        vecs[3]  = mk(6'b000000, 6'b100011, 1, 0, 4, 1, 0, 1, 0, 1);
        vecs[4]  = mk(6'b000000, 6'b100101, 0, 0, 4, 1, 0, 1, 0, 1);
        vecs[5]  = mk(6'b000000, 6'b101010, 0, 0, 4, 1, 0, 1, 0, 1);
        vecs[6]  = mk(6'b001000, 6'b000000, 0, 0, 4, 1, 0, 1, 0, 1);
        vecs[7]  = mk(6'b001101, 6'b000000, 0, 1, 4, 1, 0, 1, 0, 1);
        vecs[8]  = mk(6'b000100, 6'b000000, 1, 0, 3, 0, 0, 2, 0, 1);
        vecs[9]  = mk(6'b000100, 6'b000000, 0, 0, 3, 0, 0, 1, 0, 1);
        vecs[10] = mk(6'b000010, 6'b000000, 0, 0, 3, 0, 0, 2, 0, 1);
        vecs[11] = mk(6'b111111, 6'b000000, 0, 0, 2, 0, 0, 1, 1, 0);
        vecs[12] = mk(6'b000000, 6'b100000, 0, 0, 2, 0, 0, 1, 1, 0);
        vecs[13] = mk(6'b000011, 6'b000000, 0, 0, 2, 0, 0, 1, 1, 0);
        vecs[14] = mk(6'b001000, 6'b000000, 0, 1, 4, 0, 0, 1, 0, 1);
        op_list = '{6'b000000, 6'b000000, 6'b001000, 6'b001101,
                    6'b100011, 6'b101011, 6'b000100, 6'b000010};
        fn_list = '{6'b100001, 6'b100011, 6'b100101, 6'b101010};
        lw_states = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};

        // Reset
        rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; upover = 1'b0;
        exp_cnt = '0; exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ir_wr", 32'(ir_wr), 32'd1);
        chk("rst_pc_wr", 32'(pc_wr), 32'd1);
        chk("rst_alu_src_b", 32'(alu_src_b), 32'd1);
        chk("rst_reg_wr", 32'(reg_wr), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_cnt", instr_cnt, 32'd0);
        chk("rst_ovf", 32'(ovf_flag), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // lw, cycle by cycle
        op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("lw_state_c%0d", i), 32'(state), 32'(lw_states[i]));
            chk($sformatf("lw_reg_wr_c%0d", i), 32'(reg_wr), (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("lw_mem_to_reg_c%0d", i), 32'(mem_to_reg), (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("lw_i_or_d_c%0d", i), 32'(i_or_d), (i == 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("lw_end_state", 32'(state), 32'd0);
        chk("lw_cnt", instr_cnt, 32'd1);

        // slt
        op = 6'b000000; funct = 6'b101010;
        go_to(4'd6);
        chk("slt_alu_ctr", 32'(alu_ctr), 32'd3);
        chk("slt_alu_src_a", 32'(alu_src_a), 32'd1);
        chk("slt_alu_src_b", 32'(alu_src_b), 32'd0);
        step();
        chk("slt_wb_state", 32'(state), 32'd7);
        chk("slt_reg_dst", 32'(reg_dst), 32'd1);
        chk("slt_reg_wr", 32'(reg_wr), 32'd1);
        go_to(4'd0);
        chk("slt_cnt", instr_cnt, 32'd2);

        // ori
        op = 6'b001101;
        go_to(4'd6);
        chk("ori_ext_zero", 32'(ext_zero), 32'd1);
        chk("ori_alu_ctr", 32'(alu_ctr), 32'd2);
        chk("ori_alu_src_b", 32'(alu_src_b), 32'd2);
        go_to(4'd7);
        chk("ori_reg_dst", 32'(reg_dst), 32'd0);
        go_to(4'd0);

        // beq taken, then zero flips within the BRANCH cycle
        op = 6'b000100; zero = 1'b1;
        go_to(4'd8);
        chk("beq_t_pc_wr", 32'(pc_wr), 32'd1);
        chk("beq_t_pc_src", 32'(pc_src), 32'd1);
        chk("beq_t_alu_ctr", 32'(alu_ctr), 32'd1);
        zero = 1'b0;
        #1;
        chk("beq_comb_pc_wr", 32'(pc_wr), 32'd0);
        go_to(4'd0);
        chk("beq_t_cnt", instr_cnt, 32'd4);
        go_to(4'd8);
        chk("beq_nt_pc_wr", 32'(pc_wr), 32'd0);
        go_to(4'd0);
        chk("beq_nt_cnt", instr_cnt, 32'd5);

        // addi overflow, then addu with upover still writes
        op = 6'b001000; upover = 1'b1;
        go_to(4'd7);
        chk("addi_ov_reg_wr", 32'(reg_wr), 32'd0);
        go_to(4'd0);
        chk("addi_ov_flag", 32'(ovf_flag), 32'd1);
        chk("addi_ov_cnt", instr_cnt, 32'd6);
        op = 6'b000000; funct = 6'b100001;
        go_to(4'd7);
        chk("addu_ov_reg_wr", 32'(reg_wr), 32'd1);
        go_to(4'd0);
        chk("addu_ov_flag_held", 32'(ovf_flag), 32'd1);
        upover = 1'b0;

        // illegal opcode
        op = 6'b111111;
        step();
        chk("ill_state", 32'(state), 32'd1);
        chk("ill_pulse", 32'(illegal), 32'd1);
        step();
        chk("ill_back", 32'(state), 32'd0);
        chk("ill_pulse_off", 32'(illegal), 32'd0);
        chk("ill_cnt", instr_cnt, 32'd7);
        exp_cnt = 32'd7; exp_ovf = 1'b1;

        // Vector table
        for (int i = 0; i < 15; i++)
            do_instr($sformatf("vec%0d", i), vecs[i]);

        // Random instructions vs. model
        for (int i = 0; i < 150; i++) begin
            r = $urandom;
            ro = (r[3:0] < 4'd8) ? op_list[r[2:0]] : r[9:4];
            rf = (r[12:10] < 3'd5) ? fn_list[r[14:13]] : r[20:15];
            do_instr($sformatf("rnd%0d", i), model(ro, rf, r[21], r[22]));
        end

        // Reset mid-MEMWR
        op = 6'b101011; zero = 1'b0; upover = 1'b0;
        go_to(4'd5);
        chk("sw_mem_wr", 32'(mem_wr), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_cnt", instr_cnt, 32'd0);
        chk("midrst_cnt4", 32'(w_instr_cnt), 32'd0);
        chk("midrst_ovf", 32'(ovf_flag), 32'd0);
        #2 rst_n = 1'b1;
        exp_cnt = '0; exp_ovf = 1'b0;

        // 16 jumps wrap the 4-bit counter
        for (int i = 0; i < 16; i++)
            do_instr($sformatf("wrap%0d", i), model(6'b000010, 6'b000000, 1'b0, 1'b0));
        chk("wrap_cnt4_zero", 32'(w_instr_cnt), 32'd0);
        chk("wrap_cnt32", instr_cnt, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit. It sits directly upstream of the ALU.
- It decodes the registered instruction (op/funct) and sequences fetch/decode/execute/memory/writeback.
- It drives alu_ctr (00 add, 01 sub, 10 or, 11 slt) and the datapath enables and muxes.
- It consumes the ALU's zero and upover outputs to resolve beq and to suppress addi writeback on overflow.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- RESET_STATE, 4'd0, state code entered on reset (FETCH)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- zero  in  1  ALU zero flag
- upover  in  1  ALU signed add overflow flag
- pc_wr  out  1  PC write enable
- ir_wr  out  1  IR write enable
- mem_wr  out  1  data memory write
- reg_wr  out  1  register file write
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- reg_dst  out  1  dest: 0=rt, 1=rd
- mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=4, 10=ext imm, 11=sext imm<<2
- ext_zero  out  1  1=zero-extend imm (ori), else sign-extend
- pc_src  out  2  00=ALU result, 01=ALUOut reg, 10=jump target
- alu_ctr  out  2  ALU operation
- state  out  4  current state code
- ovf_flag  out  1  sticky overflow seen
- illegal  out  1  one-cycle pulse, unsupported opcode decoded
- instr_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, rst_n=0): state=FETCH (0); ov_q, ovf_flag, illegal and instr_cnt = 0.
- All enables are combinational from state; in FETCH they assert immediately after reset release.
- Supported instructions: R-type (op 000000) addu 100001, subu 100011, or 100101, slt 101010; addi 001000; ori 001101; lw 100011; sw 101011; beq 000100; j 000010.
- States and Moore outputs (unlisted outputs are 0):
  - FETCH(0): ir_wr=1, pc_wr=1, alu_src_a=0, alu_src_b=01, alu_ctr=00, pc_src=00. Next DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_ctr=00 (branch target into ALUOut).
    - lw/sw -> MEMADR; R-type/addi/ori -> EXE; beq -> BRANCH; j -> JUMP.
    - Any other opcode, or R-type with an unsupported funct -> FETCH with illegal=1 for that cycle.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_ctr=00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): i_or_d=1. Next MEMWB.
  - MEMWB(4): reg_wr=1, mem_to_reg=1, reg_dst=0. Next FETCH.
  - MEMWR(5): i_or_d=1, mem_wr=1. Next FETCH.
  - EXE(6): alu_src_a=1.
    - R-type: alu_src_b=00; alu_ctr = addu 00, subu 01, or 10, slt 11.
    - addi: alu_src_b=10, alu_ctr=00.
    - ori: alu_src_b=10, ext_zero=1, alu_ctr=10.
    - On exit, ov_q <= upover & (op==addi). Next ALUWB.
  - ALUWB(7): reg_dst = R-type, mem_to_reg=0, reg_wr = !ov_q. If ov_q, ovf_flag <= 1 (sticky until reset). Next FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_ctr=01, pc_src=01, pc_wr=zero (combinational from ALU in the same cycle). Next FETCH.
  - JUMP(9): pc_src=10, pc_wr=1. Next FETCH.
  - Codes 10-15: unreachable; if entered, next state FETCH and all outputs 0.
- upover is ignored for addu/subu. alu_ctr=00 in every state not listed otherwise.
- instr_cnt increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP.
  - This includes a not-taken beq and an overflowed addi; it excludes the illegal path.
  - instr_cnt wraps modulo 2^CNT_W.
- Latencies (cycles):
  - lw 5
  - sw 4
  - R-type, addi, ori 4
  - beq 3
  - j 3
  - illegal 2
- Reset asserted mid-instruction: immediate return to FETCH; no further writes are issued; counter and flags clear.

Test Plan:
- Reset then release, op=100011 (lw) -> states 0,1,2,3,4,0; reg_wr=1 and mem_to_reg=1 only in state 4; instr_cnt=1.
- op=000000, funct=101010 (slt) -> alu_ctr=11 in EXE; ALUWB has reg_dst=1, reg_wr=1; 4 cycles.
- op=000100 (beq) with zero=1 in BRANCH -> pc_wr=1, pc_src=01; repeat with zero=0 -> pc_wr=0; instr_cnt +1 in both cases.
- op=001000 (addi) with upover=1 in EXE -> ALUWB reg_wr=0, ovf_flag=1 and held across a following addu with upover=1 (addu writes normally).
- op=111111 -> DECODE pulses illegal=1, back to FETCH after 2 cycles, instr_cnt unchanged.
- rst_n dropped during MEMWR mid-cycle -> mem_wr falls immediately, state=0, instr_cnt=0; CNT_W=4 run of 16 instructions -> instr_cnt wraps to 0.
